// File: rtl/coin_start_seq.sv
// Turns Start 1P/2P requests into a timed coin pulse, settle gap and start pulse,
// counted in ENA ticks. Define DOUBLE_COIN_EN to make a 2P start insert two coins.
module coin_start_seq #(
  parameter int CNT_W       = 21,
  parameter int COIN_TICKS  = 600000,
  parameter int GAP_TICKS   = 1200000,
  parameter int START_TICKS = 600000
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic ENA,
  input  logic req_start1,
  input  logic req_start2,
  input  logic req_coin,
  output logic coin_out,
  output logic start1_out,
  output logic start2_out,
  output logic busy
);

  if (COIN_TICKS < 1 || GAP_TICKS < 1 || START_TICKS < 1) begin : g_bad_ticks
    $error("coin_start_seq: tick parameters must be at least 1");
  end

  localparam logic [CNT_W-1:0] COIN_LD  = CNT_W'(COIN_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] START_LD = CNT_W'(START_TICKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COIN,
    ST_GAP,
    ST_START,
    ST_RELEASE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       r1_q, r1_d;
  logic [1:0]       r2_q, r2_d;
  logic [1:0]       arm_q, arm_d;
  logic             coin_q, coin_d;
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [1:0]       rise;
`ifdef DOUBLE_COIN_EN
  logic             coin_idx_q, coin_idx_d;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      arm_q      <= '0;
      coin_q     <= 1'b0;
      sel_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef DOUBLE_COIN_EN
      coin_idx_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      arm_q      <= arm_d;
      coin_q     <= coin_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
`ifdef DOUBLE_COIN_EN
      coin_idx_q <= coin_idx_d;
`endif
    end
  end

  // Edge detect is armed only once both sample stages hold post-reset data,
  // so a button held through reset is not mistaken for a fresh press.
  always_comb begin
    r1_d   = {req_start2, req_start1};
    r2_d   = r1_q;
    arm_d  = {arm_q[0], 1'b1};
    coin_d = req_coin;
    busy_d = (state_q != ST_IDLE);
    rise   = r1_q & ~r2_q & {2{arm_q[1]}};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
`ifdef DOUBLE_COIN_EN
    coin_idx_d = coin_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|rise) begin
          sel_d   = ~rise[0];
          cnt_d   = COIN_LD;
          state_d = ST_COIN;
`ifdef DOUBLE_COIN_EN
          coin_idx_d = 1'b0;
`endif
        end
      end
      ST_COIN: begin
        if (ENA) begin
          if (cnt_q == '0) begin
            cnt_d   = GAP_LD;
            state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (ENA) begin
          if (cnt_q == '0) begin
`ifdef DOUBLE_COIN_EN
            if (sel_q && !coin_idx_q) begin
              coin_idx_d = 1'b1;
              cnt_d      = COIN_LD;
              state_d    = ST_COIN;
            end else begin
              cnt_d   = START_LD;
              state_d = ST_START;
            end
`else
            cnt_d   = START_LD;
            state_d = ST_START;
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_START: begin
        if (ENA) begin
          if (cnt_q == '0) begin
            state_d = ST_RELEASE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_RELEASE: begin
        if (r1_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    coin_out   = (state_q == ST_COIN) | coin_q;
    start1_out = (state_q == ST_START) & ~sel_q;
    start2_out = (state_q == ST_START) & sel_q;
    busy       = busy_q;
  end

endmodule

// File: tb/tb_coin_start_seq.sv
// Scoreboard bench for coin_start_seq: ENA every 4th CLK, output runs measured in ENA ticks.
module tb_coin_start_seq;

  localparam int COIN_T  = 4;
  localparam int GAP_T   = 3;
  localparam int START_T = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic req_start1 = 1'b0;
  logic req_start2 = 1'b0;
  logic req_coin = 1'b0;
  logic coin_out, start1_out, start2_out, busy;

  typedef struct packed {
    logic [2:0] pat;
    int         len;
  } run_t;

  run_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ph = 0;

  coin_start_seq #(
    .CNT_W      (4),
    .COIN_TICKS (COIN_T),
    .GAP_TICKS  (GAP_T),
    .START_TICKS(START_T)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .ENA       (ena),
    .req_start1(req_start1),
    .req_start2(req_start2),
    .req_coin  (req_coin),
    .coin_out  (coin_out),
    .start1_out(start1_out),
    .start2_out(start2_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ena = (ph == 3);
      ph  = (ph + 1) % 4;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic run_t mk(input logic [2:0] pat, input int len);
    run_t r;
    r.pat = pat;
    r.len = len;
    return r;
  endfunction

  // Output monitor: groups ENA-cycle samples of {coin,start1,start2} into runs.
  // Zero runs are scored only when they follow a coin run while the FSM is busy (gaps).
  logic [2:0] run_pat = '0;
  logic [2:0] prev_pat = '0;
  int         run_len = 0;
  logic       run_busy_all = 1'b0;

  always @(negedge clk) begin
    logic [2:0] pat;
    run_t       e;
    if (!rst_n) begin
      run_len  = 0;
      run_pat  = '0;
      prev_pat = '0;
    end else if (ena) begin
      pat = {coin_out, start1_out, start2_out};
      if (run_len > 0 && pat != run_pat) begin
        if (run_pat != 3'b000 || (prev_pat == 3'b100 && run_busy_all)) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got pat=%b len=%0d, required no output run", run_pat, run_len);
          end else begin
            e = exp_q.pop_front();
            if (run_pat !== e.pat || run_len != e.len) begin
              errors++;
              $display("FAIL sb_run: got pat=%b len=%0d, required pat=%b len=%0d",
                       run_pat, run_len, e.pat, e.len);
            end
          end
        end
        prev_pat = run_pat;
        run_len  = 0;
      end
      if (run_len == 0) begin
        run_pat      = pat;
        run_busy_all = 1'b1;
      end
      run_len++;
      if (!busy) run_busy_all = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_seq(input bit two_p);
    exp_q.push_back(mk(3'b100, COIN_T));
    exp_q.push_back(mk(3'b000, GAP_T));
`ifdef DOUBLE_COIN_EN
    if (two_p) begin
      exp_q.push_back(mk(3'b100, COIN_T));
      exp_q.push_back(mk(3'b000, GAP_T));
    end
`endif
    exp_q.push_back(mk(two_p ? 3'b001 : 3'b010, START_T));
  endtask

  task automatic wait_done(input string name, input int budget, input bit need_idle);
    int n = 0;
    while ((exp_q.size() != 0 || (need_idle && busy)) && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || (need_idle && busy)) begin
      errors++;
      $display("FAIL %s: timeout, pending=%0d busy=%b, required pending=0%s",
               name, exp_q.size(), busy, need_idle ? " busy=0" : "");
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    req_start1 = 1'b1;
    tick(5);
    checks++;
    if ({coin_out, start1_out, start2_out, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: got %b, required 0000", {coin_out, start1_out, start2_out, busy});
    end
    rst_n = 1'b1;
    tick(40);
    checks++;
    if ({coin_out, start1_out, start2_out, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held_button: got %b, required 0000", {coin_out, start1_out, start2_out, busy});
    end
    req_start1 = 1'b0;
    tick(8);
  endtask

  task automatic test_one_player;
    req_start1 = 1'b1;
    push_seq(1'b0);
    tick(100);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL p1_release_hold: got pending=%0d busy=%b, required pending=0 busy=1", exp_q.size(), busy);
    end
    req_start1 = 1'b0;
    tick(2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL p1_busy_late: got %b, required 1", busy);
    end
    tick(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL p1_busy_drop: got %b, required 0", busy);
    end
    tick(8);
  endtask

  task automatic test_simultaneous;
    req_start1 = 1'b1;
    req_start2 = 1'b1;
    push_seq(1'b0);
    tick(4);
    req_start1 = 1'b0;
    req_start2 = 1'b0;
    wait_done("simul_done", 300, 1'b1);
    tick(8);
  endtask

  task automatic test_lockout_hold;
    req_start2 = 1'b1;
    push_seq(1'b1);
    tick(22);
    req_start1 = 1'b1;
    tick(4);
    req_start1 = 1'b0;
    wait_done("lock_seq", 400, 1'b0);
    tick(60);
    checks++;
    if (busy !== 1'b1 || coin_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got busy=%b coin=%b, required busy=1 coin=0", busy, coin_out);
    end
    req_start2 = 1'b0;
    wait_done("hold_exit", 50, 1'b1);
    tick(8);
  endtask

  task automatic test_reset_mid;
    int n = 0;
    req_start1 = 1'b1;
    exp_q.push_back(mk(3'b100, COIN_T));
    exp_q.push_back(mk(3'b000, GAP_T));
    tick(4);
    req_start1 = 1'b0;
    while (start1_out !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    if (start1_out !== 1'b1) begin
      errors++;
      $display("FAIL rmid_start: timeout, got start1=%b, required 1", start1_out);
    end
    tick(6);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({coin_out, start1_out, start2_out, busy} !== 4'b0000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rmid_drop: got %b pending=%0d, required 0000 pending=0",
               {coin_out, start1_out, start2_out, busy}, exp_q.size());
      exp_q.delete();
    end
    tick(3);
    rst_n = 1'b1;
    tick(4);
    exp_q.push_back(mk(3'b100, 2));
    req_coin = 1'b1;
    tick(2);
    checks++;
    if (coin_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_coin: got coin=%b busy=%b, required coin=1 busy=0", coin_out, busy);
    end
    tick(6);
    req_coin = 1'b0;
    tick(10);
    checks++;
    if (coin_out !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rmid_idle: got coin=%b busy=%b pending=%0d, required 0 0 0",
               coin_out, busy, exp_q.size());
    end
  endtask

  task automatic test_two_player;
    req_start2 = 1'b1;
    push_seq(1'b1);
    tick(4);
    req_start2 = 1'b0;
    wait_done("p2_done", 400, 1'b1);
    tick(8);
  endtask

  initial begin
    test_reset();
    test_one_player();
    test_simultaneous();
    test_lockout_hold();
    test_reset_mid();
    test_two_player();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: got pending=%0d, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
